// File: rtl/opu_fetch_pkg.sv
// Shared constants and types for the OPU input fetcher: APB register map,
// fetch FSM states and vector width helper.
package opu_fetch_pkg;

    localparam int ADDR_INDEX   = 'h30;
    localparam int ADDR_PAYLOAD = 'h34;
    localparam int ADDR_RELEASE = 'h38;
    localparam int ADDR_STATUS  = 'h3C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL,
        ST_WIDX,
        ST_RPAY,
        ST_REL,
        ST_PRESENT
    } fetch_state_t;

    function automatic int calc_vec_w(input int words, input int dw);
        return words * dw;
    endfunction

endpackage

// File: rtl/apb_master_port.sv
// Single-outstanding APB master: launches one SETUP/ACCESS transfer per request
// and reports completion with a combinational done pulse on the ready edge.
module apb_master_port #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic          write,
    input  logic [DW-1:0] wdata,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          psel,
    output logic          penable,
    output logic [AW-1:0] paddr,
    output logic          pwrite,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready
);

    assign done  = psel & penable & pready;
    assign rdata = prdata;

    // A new request is taken on the completing edge so transfers run back to back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            paddr   <= '0;
            pwrite  <= 1'b0;
            pwdata  <= '0;
        end else if (req && (!psel || done)) begin
            psel    <= 1'b1;
            penable <= 1'b0;
            paddr   <= addr;
            pwrite  <= write;
            pwdata  <= wdata;
        end else if (psel && !penable) begin
            penable <= 1'b1;
        end else if (done) begin
            psel    <= 1'b0;
            penable <= 1'b0;
        end
    end

endmodule

// File: rtl/opu_input_fetcher.sv
// Hardware fetch loop: polls the input buffer status, reads one vector as
// index/payload pairs, releases the buffer and hands the vector to the OPU.
module opu_input_fetcher
    import opu_fetch_pkg::*;
#(
    parameter int BUS_AW        = 6,
    parameter int BUS_DW        = 32,
    parameter int WORDS_PER_VEC = 36,
    parameter int CNT_W         = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            enable_i,
    output logic [BUS_AW-1:0]               m_paddr_o,
    output logic                            m_pwrite_o,
    output logic                            m_psel_o,
    output logic                            m_penable_o,
    output logic [BUS_DW-1:0]               m_pwdata_o,
    input  logic [BUS_DW-1:0]               m_prdata_i,
    input  logic                            m_pready_i,
    output logic [WORDS_PER_VEC*BUS_DW-1:0] opu_vec_o,
    output logic                            opu_valid_o,
    input  logic                            opu_ready_i,
    output logic                            busy_o,
    output logic [CNT_W-1:0]                vec_cnt_o
);

    localparam int VEC_W = calc_vec_w(WORDS_PER_VEC, BUS_DW);
    localparam int IDX_W = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_VEC - 1);

    fetch_state_t      state;
    logic [IDX_W-1:0]  idx;
    logic [VEC_W-1:0]  shadow;

    logic              req;
    logic [BUS_AW-1:0] req_addr;
    logic              req_write;
    logic [BUS_DW-1:0] req_wdata;
    logic              xfer_done;
    logic [BUS_DW-1:0] rdata;

    apb_master_port #(
        .AW (BUS_AW),
        .DW (BUS_DW)
    ) u_apb (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .req     (req),
        .addr    (req_addr),
        .write   (req_write),
        .wdata   (req_wdata),
        .done    (xfer_done),
        .rdata   (rdata),
        .psel    (m_psel_o),
        .penable (m_penable_o),
        .paddr   (m_paddr_o),
        .pwrite  (m_pwrite_o),
        .pwdata  (m_pwdata_o),
        .prdata  (m_prdata_i),
        .pready  (m_pready_i)
    );

    // Request for the transfer that follows the current state's exit, so the
    // port can start its SETUP on the same edge the FSM advances.
    always_comb begin
        req       = 1'b0;
        req_addr  = BUS_AW'(ADDR_STATUS);
        req_write = 1'b0;
        req_wdata = '0;
        case (state)
            ST_IDLE: req = enable_i;
            ST_POLL: begin
                if (xfer_done) begin
                    if (rdata[0]) begin
                        req       = 1'b1;
                        req_addr  = BUS_AW'(ADDR_INDEX);
                        req_write = 1'b1;
                    end else begin
                        req = enable_i;
                    end
                end
            end
            ST_WIDX: begin
                req      = xfer_done;
                req_addr = BUS_AW'(ADDR_PAYLOAD);
            end
            ST_RPAY: begin
                req       = xfer_done;
                req_write = 1'b1;
                if (idx == LAST_IDX) begin
                    req_addr  = BUS_AW'(ADDR_RELEASE);
                    req_wdata = BUS_DW'(1);
                end else begin
                    req_addr  = BUS_AW'(ADDR_INDEX);
                    req_wdata = BUS_DW'(idx) + BUS_DW'(1);
                end
            end
            ST_PRESENT: req = opu_valid_o & opu_ready_i & enable_i;
            default: req = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= ST_IDLE;
            idx         <= '0;
            shadow      <= '0;
            opu_vec_o   <= '0;
            opu_valid_o <= 1'b0;
            vec_cnt_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable_i) state <= ST_POLL;
                end
                ST_POLL: begin
                    if (xfer_done) begin
                        if (rdata[0]) begin
                            idx   <= '0;
                            state <= ST_WIDX;
                        end else if (!enable_i) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WIDX: begin
                    if (xfer_done) state <= ST_RPAY;
                end
                ST_RPAY: begin
                    if (xfer_done) begin
                        shadow[int'(idx)*BUS_DW +: BUS_DW] <= rdata;
                        if (idx == LAST_IDX) begin
                            state <= ST_REL;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= ST_WIDX;
                        end
                    end
                end
                ST_REL: begin
                    if (xfer_done) state <= ST_PRESENT;
                end
                ST_PRESENT: begin
                    // First PRESENT cycle publishes the shadow; the vector then
                    // holds until the OPU takes it.
                    if (!opu_valid_o) begin
                        opu_vec_o   <= shadow;
                        opu_valid_o <= 1'b1;
                    end else if (opu_ready_i) begin
                        opu_valid_o <= 1'b0;
                        vec_cnt_o   <= vec_cnt_o + 1'b1;
                        state       <= enable_i ? ST_POLL : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_opu_input_fetcher.sv
// Directed bench for opu_input_fetcher with a behavioural APB input-buffer slave.
module tb_opu_input_fetcher;

    localparam int VEC_W = 1152;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic [5:0]       paddr;
    logic             pwrite;
    logic             psel;
    logic             penable;
    logic [31:0]      pwdata;
    logic [31:0]      prdata;
    logic             pready;
    logic [VEC_W-1:0] vec;
    logic             valid;
    logic             opu_ready = 1'b0;
    logic             busy;
    logic [15:0]      cnt;

    int total = 0;
    int bad = 0;

    int status_reads = 0;
    int status_thresh = 0;
    int idx_writes = 0;
    int idx_seq_err = 0;
    int rel_writes = 0;
    int rel_bad = 0;
    int unstable = 0;
    int sr_at_idx0 = 0;
    int w17_len = 0;
    int acc_len = 0;
    int psel_cycles = 0;
    logic [31:0] cur_idx = 32'd0;
    logic [31:0] idx_next = 32'd0;
    logic [5:0]  setup_addr = 6'd0;
    logic        setup_wr = 1'b0;
    logic [31:0] setup_wd = 32'd0;
    logic        stall_en = 1'b0;

    always #5 clk = ~clk;

    opu_input_fetcher dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .enable_i    (enable),
        .m_paddr_o   (paddr),
        .m_pwrite_o  (pwrite),
        .m_psel_o    (psel),
        .m_penable_o (penable),
        .m_pwdata_o  (pwdata),
        .m_prdata_i  (prdata),
        .m_pready_i  (pready),
        .opu_vec_o   (vec),
        .opu_valid_o (valid),
        .opu_ready_i (opu_ready),
        .busy_o      (busy),
        .vec_cnt_o   (cnt)
    );

    always_comb begin
        prdata = 32'd0;
        if (paddr == 6'h3C) prdata = {31'd0, (status_reads >= status_thresh)};
        else if (paddr == 6'h34) prdata = 32'hA500_0000 | cur_idx;
    end

    assign pready = !(stall_en && paddr == 6'h34 && cur_idx == 32'd17 && acc_len < 3);

    always @(posedge clk) begin
        if (psel) psel_cycles <= psel_cycles + 1;
        if (psel && !penable) begin
            setup_addr <= paddr;
            setup_wr   <= pwrite;
            setup_wd   <= pwdata;
            acc_len    <= 0;
        end
        if (psel && penable) begin
            if (paddr !== setup_addr || pwrite !== setup_wr || pwdata !== setup_wd)
                unstable <= unstable + 1;
            if (!pready) begin
                acc_len <= acc_len + 1;
            end else begin
                acc_len <= 0;
                if (!pwrite && paddr == 6'h3C) status_reads <= status_reads + 1;
                if (!pwrite && paddr == 6'h34 && cur_idx == 32'd17) w17_len <= acc_len + 1;
                if (pwrite && paddr == 6'h30) begin
                    idx_writes <= idx_writes + 1;
                    cur_idx    <= pwdata;
                    idx_next   <= pwdata + 32'd1;
                    if (pwdata != 32'd0 && pwdata != idx_next) idx_seq_err <= idx_seq_err + 1;
                    if (pwdata == 32'd0) sr_at_idx0 <= status_reads;
                end
                if (pwrite && paddr == 6'h38) begin
                    rel_writes <= rel_writes + 1;
                    if (pwdata != 32'd1) rel_bad <= rel_bad + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (cyc < 2000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (valid === 1'b1) break;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        opu_ready = 1'b1;
        @(posedge clk);
        #1;
        opu_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        int sr0;
        int iw0;
        int rel0;
        int ps0;
        logic [VEC_W-1:0] vec_snap;

        #1;
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_vec_zero", (vec === '0), 1'b1);
        chk("rst_cnt", cnt, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_paddr", paddr, 6'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Basic vector: zero waits, status ready at first poll.
        iw0  = idx_writes;
        rel0 = rel_writes;
        @(negedge clk);
        enable = 1'b1;
        @(posedge clk);
        wait_valid(cyc);
        chk("t1_latency", cyc, 149);
        for (int i = 0; i < 36; i++)
            chk($sformatf("t1_word%0d", i), vec[i*32 +: 32], 32'hA500_0000 | 32'(i));
        chk("t1_index_writes", idx_writes - iw0, 36);
        chk("t1_index_order", idx_seq_err, 0);
        chk("t1_release_count", rel_writes - rel0, 1);
        chk("t1_release_data", rel_bad, 0);
        chk("t1_busy", busy, 1'b1);

        // OPU back-pressure: vector held, bus quiet.
        vec_snap = vec;
        ps0 = psel_cycles;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_valid_held", valid, 1'b1);
        chk("t4_vec_stable", (vec === vec_snap), 1'b1);
        chk("t4_no_apb", psel_cycles - ps0, 0);
        chk("t4_cnt_before", cnt, 16'd0);

        // Next vector sees five not-ready polls.
        sr0 = status_reads;
        status_thresh = status_reads + 5;
        handshake();
        chk("t4_valid_clear", valid, 1'b0);
        chk("t4_cnt_after", cnt, 16'd1);
        chk("t4_poll_psel", psel, 1'b1);
        chk("t4_poll_penable", penable, 1'b0);
        chk("t4_poll_addr", paddr, 6'h3C);
        wait_valid(cyc);
        chk("t2_latency", cyc, 159);
        chk("t2_status_reads", status_reads - sr0, 6);
        chk("t2_first_index_after", sr_at_idx0, sr0 + 6);
        chk("t2_word35", vec[35*32 +: 32], 32'hA500_0023);

        // Payload word 17 stalls three cycles.
        stall_en = 1'b1;
        handshake();
        chk("t3_cnt", cnt, 16'd2);
        wait_valid(cyc);
        stall_en = 1'b0;
        chk("t3_latency", cyc, 152);
        chk("t3_w17_access_len", w17_len, 4);
        chk("t3_word17", vec[17*32 +: 32], 32'hA500_0011);
        chk("t3_word18", vec[18*32 +: 32], 32'hA500_0012);
        chk("t3_bus_stable", unstable, 0);

        // Enable dropped mid-vector: finish, deliver, then idle.
        handshake();
        chk("t5_cnt_start", cnt, 16'd3);
        cyc = 0;
        while (cyc < 2000 && cur_idx != 32'd20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t5_reach_word20", cur_idx, 32'd20);
        enable = 1'b0;
        wait_valid(cyc);
        chk("t5_valid", valid, 1'b1);
        chk("t5_word20", vec[20*32 +: 32], 32'hA500_0014);
        chk("t5_word35", vec[35*32 +: 32], 32'hA500_0023);
        sr0 = status_reads;
        handshake();
        chk("t5_cnt", cnt, 16'd4);
        chk("t5_busy_after", busy, 1'b0);
        chk("t5_psel_after", psel, 1'b0);
        ps0 = psel_cycles;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_no_status", status_reads - sr0, 0);
        chk("t5_no_apb", psel_cycles - ps0, 0);
        chk("t5_busy_idle", busy, 1'b0);

        // Reset in the ACCESS phase of payload word 10.
        rel0 = rel_writes;
        enable = 1'b1;
        cyc = 0;
        while (cyc < 2000 && !(psel && penable && paddr == 6'h34 && cur_idx == 32'd10)) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t6_reach_word10", (psel && penable && paddr == 6'h34 && cur_idx == 32'd10), 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_psel", psel, 1'b0);
        chk("t6_penable", penable, 1'b0);
        chk("t6_valid", valid, 1'b0);
        chk("t6_cnt", cnt, 16'd0);
        chk("t6_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        while (cyc < 50 && psel !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("t6_restart_psel", psel, 1'b1);
        chk("t6_restart_addr", paddr, 6'h3C);
        chk("t6_restart_read", pwrite, 1'b0);
        chk("t6_no_release", rel_writes - rel0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/opu_input_fetcher.md
Name: opu_input_fetcher

Overview:
- APB master sitting directly downstream of apb_input_buffer_top, in front of the OPU datapath.
- Polls OPU_INPUT_STATUS until a 1152-bit vector is ready, then reads it as 36 index/payload word pairs.
- Writes OPU_INPUT_RELEASE, then presents the assembled vector to the OPU with a valid/ready handshake.
- Replaces the software read loop with hardware sequencing.

Parameters:
- BUS_AW, 6, APB address width.
- BUS_DW, 32, APB data width.
- WORDS_PER_VEC, 36, payload words per vector; VEC_W = WORDS_PER_VEC*BUS_DW = 1152.
- CNT_W, 16, width of the delivered-vector counter.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  level; 1 = keep fetching vectors.
- m_paddr_o  out  BUS_AW  APB address.
- m_pwrite_o  out  1  APB write.
- m_psel_o  out  1  APB select.
- m_penable_o  out  1  APB enable.
- m_pwdata_o  out  BUS_DW  APB write data.
- m_prdata_i  in  BUS_DW  APB read data.
- m_pready_i  in  1  APB ready.
- opu_vec_o  out  VEC_W  assembled vector; word i at bits [i*32 +: 32].
- opu_valid_o  out  1  vector valid.
- opu_ready_i  in  1  OPU accepts.
- busy_o  out  1  FSM not in IDLE.
- vec_cnt_o  out  CNT_W  vectors delivered, wraps.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n_i is asynchronous and active-low.
- Reset values: all outputs 0, including m_psel_o, m_penable_o, opu_valid_o, opu_vec_o, vec_cnt_o and busy_o. FSM returns to IDLE and the word index resets to 0.
- Reset mid-transfer: the APB strobes drop immediately; no release is issued.
- APB transfer engine:
  - SETUP cycle: psel=1, penable=0, paddr/pwrite/pwdata driven.
  - ACCESS cycle(s): psel=1, penable=1, held until pready=1 is sampled at a clock edge.
  - Read data is captured on that same edge.
  - The next SETUP may follow in the very next cycle.
  - With zero wait states a transfer takes 2 cycles.
  - paddr, pwrite and pwdata stay stable from SETUP through end of ACCESS.
  - After the final transfer psel and penable return to 0 in the next cycle.
- Register addresses: STATUS 0x3C (R), INDEX 0x30 (W), PAYLOAD 0x34 (R), RELEASE 0x38 (W, data 1).
- FSM states:
  - IDLE: if enable_i=1, go to POLL.
  - POLL: read STATUS. If prdata[0]=0, retry with an immediate new SETUP; if enable_i=0 at that point, go to IDLE instead. If prdata[0]=1, clear idx and go to WIDX.
  - WIDX: write INDEX with data = idx, zero-extended.
  - RPAY: read PAYLOAD into word slot idx of an internal shadow register. If idx=WORDS_PER_VEC-1, go to REL; else idx++ and return to WIDX.
  - REL: write RELEASE with data 1.
  - PRESENT: on the cycle after the REL access completes, copy shadow to opu_vec_o and set opu_valid_o=1.
  - PRESENT exit: stay while opu_ready_i=0. On opu_valid_o & opu_ready_i, clear valid, increment vec_cnt_o, then go to POLL if enable_i=1, else IDLE.
- Output stability: opu_vec_o and opu_valid_o are stable while valid=1 and ready=0. opu_vec_o keeps its last value after the handshake.
- enable_i deassertion never aborts an in-progress vector; the fetcher finishes through PRESENT.
- Minimum latency (zero waits, status ready at first poll):
  - 2 (status) + 36×4 (index + payload) + 2 (release) = 148 cycles from leaving IDLE to the last ACCESS completing.
  - opu_valid_o rises 1 cycle later.
- vec_cnt_o wraps from 2^CNT_W−1 to 0.
- busy_o = (state != IDLE).

Decomposition:
- Package opu_fetch_pkg holds:
  - register address constants ADDR_STATUS, ADDR_INDEX, ADDR_PAYLOAD, ADDR_RELEASE;
  - the FSM state enum;
  - VEC_W derivation.
- One natural sub-module, apb_master_port:
  - accepts a single transfer request (addr, write, wdata);
  - runs SETUP/ACCESS;
  - returns a done pulse and rdata.
- The top FSM only sequences requests to apb_master_port.

Test Plan:
- Zero-wait slave model, status=1, payload word i = 32'hA5000000|i → opu_valid_o rises exactly 149 cycles after enable_i; opu_vec_o[i*32+:32] = A5000000+i for all 36 words; INDEX writes are 0..35 in order; one RELEASE write with data 1.
- Status returns 0 for 5 polls, then 1 → exactly 6 STATUS reads, each SETUP/ACCESS 2 cycles, no INDEX write before the 6th read completes.
- pready stalls 3 cycles on payload word 17 → penable held 4 cycles, paddr stable at 0x34, word 17 captured correctly, total latency +3.
- opu_ready_i=0 for 10 cycles in PRESENT → opu_valid_o and opu_vec_o stable, no APB activity; on ready, vec_cnt_o goes 0→1 and polling resumes the next cycle.
- enable_i dropped during word 20 → vector completes and is delivered, then IDLE with busy_o=0 and no further STATUS read.
- rst_n_i asserted mid-ACCESS of word 10 → psel/penable/opu_valid_o go 0 asynchronously, vec_cnt_o=0; after reset release with enable_i=1, the first transfer is a STATUS read.
